// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: holds NUM_DOMAINS sub-block resets, then releases them one by one (ascending) with a gap; optional ack handshake via RST_SEQ_ACK_EN.
// Latency: first release HOLD_CYC+RELEASE_DLY edges after RST rises (or after SW_RST_REQ); every output is registered.
// Backpressure: with RST_SEQ_ACK_EN each release stalls on DOM_ACK[idx] up to ACK_TIMEOUT cycles, then sticks in ERROR; without it the sequence free-runs.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYC    = 4,
    parameter int RELEASE_DLY = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOM_ACK,
    output logic [NUM_DOMAINS-1:0] DOM_RST_N,
    output logic                   SEQ_DONE,
    output logic                   SEQ_ERR,
    output logic [NUM_DOMAINS-1:0] ERR_DOM
);

    localparam int MAX_HD  = (HOLD_CYC > RELEASE_DLY) ? HOLD_CYC : RELEASE_DLY;
    localparam int MAX_CYC = (MAX_HD > ACK_TIMEOUT) ? MAX_HD : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] DLY_LD   = CNT_W'(RELEASE_DLY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

`ifdef RST_SEQ_ACK_EN
    localparam logic [CNT_W-1:0] ACK_LD = CNT_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_DLY,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_DLY,
        ST_DONE
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   armed_q;
    logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
    logic                   seq_done_q, seq_done_d;
    logic [NUM_DOMAINS-1:0] idx_onehot;
    logic                   cnt_last;

    assign idx_onehot = NUM_DOMAINS'(1) << idx_q;
    assign cnt_last   = (cnt_q <= CNT_ONE);

`ifdef RST_SEQ_ACK_EN
    logic                   seq_err_q, seq_err_d;
    logic [NUM_DOMAINS-1:0] err_dom_q, err_dom_d;
    logic                   ack_sel;

    assign ack_sel = |(DOM_ACK & idx_onehot);
`else
    logic unused_dom_ack;

    assign unused_dom_ack = ^DOM_ACK;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dom_rst_n_d = dom_rst_n_q;
        seq_done_d  = seq_done_q;
`ifdef RST_SEQ_ACK_EN
        seq_err_d   = seq_err_q;
        err_dom_d   = err_dom_q;
`endif
        if (SW_RST_REQ) begin
            state_d     = ST_HOLD;
            idx_d       = '0;
            cnt_d       = HOLD_LD;
            dom_rst_n_d = '0;
            seq_done_d  = 1'b0;
`ifdef RST_SEQ_ACK_EN
            seq_err_d   = 1'b0;
            err_dom_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    dom_rst_n_d = '0;
                    // The first edge after RST rises only arms the counter, so HOLD spans HOLD_CYC full cycles.
                    if (armed_q) begin
                        if (cnt_last) begin
                            state_d = ST_WAIT_DLY;
                            cnt_d   = DLY_LD;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                ST_WAIT_DLY: begin
                    if (cnt_last) begin
                        dom_rst_n_d = dom_rst_n_q | idx_onehot;
`ifdef RST_SEQ_ACK_EN
                        state_d = ST_WAIT_ACK;
                        cnt_d   = ACK_LD;
`else
                        if (idx_q == LAST_IDX) begin
                            state_d     = ST_DONE;
                            seq_done_d  = 1'b1;
                            dom_rst_n_d = '1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            cnt_d = DLY_LD;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
`ifdef RST_SEQ_ACK_EN
                ST_WAIT_ACK: begin
                    // An ack on the same edge as the last timeout cycle still counts as in time.
                    if (ack_sel) begin
                        if (idx_q == LAST_IDX) begin
                            state_d     = ST_DONE;
                            seq_done_d  = 1'b1;
                            dom_rst_n_d = '1;
                        end else begin
                            state_d = ST_WAIT_DLY;
                            idx_d   = idx_q + IDX_W'(1);
                            cnt_d   = DLY_LD;
                        end
                    end else if (cnt_last) begin
                        state_d     = ST_ERROR;
                        dom_rst_n_d = '0;
                        seq_err_d   = 1'b1;
                        err_dom_d   = idx_onehot;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_ERROR: begin
                    dom_rst_n_d = '0;
                    seq_err_d   = 1'b1;
                end
`endif
                ST_DONE: begin
                    dom_rst_n_d = '1;
                    seq_done_d  = 1'b1;
                end
                default: begin
                    state_d     = ST_HOLD;
                    idx_d       = '0;
                    cnt_d       = HOLD_LD;
                    dom_rst_n_d = '0;
                    seq_done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_HOLD;
            idx_q       <= '0;
            cnt_q       <= HOLD_LD;
            armed_q     <= 1'b0;
            dom_rst_n_q <= '0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            armed_q     <= 1'b1;
            dom_rst_n_q <= dom_rst_n_d;
            seq_done_q  <= seq_done_d;
        end
    end

`ifdef RST_SEQ_ACK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            seq_err_q <= 1'b0;
            err_dom_q <= '0;
        end else begin
            seq_err_q <= seq_err_d;
            err_dom_q <= err_dom_d;
        end
    end

    assign SEQ_ERR = seq_err_q;
    assign ERR_DOM = err_dom_q;

    a_err_dom_onehot: assert property (@(posedge CLK) disable iff (!RST)
        $onehot0(ERR_DOM));
`else
    assign SEQ_ERR = 1'b0;
    assign ERR_DOM = '0;
`endif

    assign DOM_RST_N = dom_rst_n_q;
    assign SEQ_DONE  = seq_done_q;

    // Released domains always form a contiguous run starting at bit 0.
    a_release_prefix: assert property (@(posedge CLK) disable iff (!RST)
        ((DOM_RST_N & (DOM_RST_N + NUM_DOMAINS'(1))) == '0));

    a_done_all_released: assert property (@(posedge CLK) disable iff (!RST)
        SEQ_DONE |-> (&DOM_RST_N));

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: event-time reference model (release edges, ack-wait start, timeout edge) checked every cycle, plus pinned literal edges.
module tb_rst_seq_ctrl;

    localparam int N    = 3;
    localparam int HOLD = 4;
    localparam int DLY  = 8;
    localparam int TO   = 255;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         SW_RST_REQ = 1'b0;
    logic [N-1:0] DOM_ACK = '0;
    logic [N-1:0] DOM_RST_N;
    logic         SEQ_DONE;
    logic         SEQ_ERR;
    logic [N-1:0] ERR_DOM;

    rst_seq_ctrl #(
        .NUM_DOMAINS (N),
        .HOLD_CYC    (HOLD),
        .RELEASE_DLY (DLY),
        .ACK_TIMEOUT (TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .DOM_ACK    (DOM_ACK),
        .DOM_RST_N  (DOM_RST_N),
        .SEQ_DONE   (SEQ_DONE),
        .SEQ_ERR    (SEQ_ERR),
        .ERR_DOM    (ERR_DOM)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @t=%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Reference model: tracks absolute edge numbers rather than counters.
    int           e       = 0;
    int           n_rel   = 0;
    bit           m_done  = 0;
    bit           m_err   = 0;
    bit           waiting = 0;
    int           t_next  = HOLD + DLY;
    int           r_edge  = 0;
    logic [N-1:0] m_err_dom = '0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e = 0; n_rel = 0; m_done = 0; m_err = 0; waiting = 0;
            t_next = HOLD + DLY; r_edge = 0; m_err_dom = '0;
        end else begin
            if (SW_RST_REQ) begin
                n_rel = 0; m_done = 0; m_err = 0; waiting = 0; m_err_dom = '0;
                t_next = e + HOLD + DLY;
            end else if (m_done || m_err) begin
            end
`ifdef RST_SEQ_ACK_EN
            else if (waiting) begin
                if (DOM_ACK[n_rel-1]) begin
                    waiting = 0;
                    if (n_rel == N) m_done = 1;
                    else t_next = e + DLY;
                end else if (e == r_edge + TO) begin
                    m_err = 1;
                    m_err_dom = N'(1 << (n_rel - 1));
                end
            end
`endif
            else if (e == t_next) begin
                n_rel++;
`ifdef RST_SEQ_ACK_EN
                waiting = 1;
                r_edge = e;
`else
                if (n_rel == N) m_done = 1;
                else t_next = e + DLY;
`endif
            end
            e++;
        end
    end

    always @(negedge CLK) begin
        check("dom_rst_n", DOM_RST_N, m_err ? '0 : N'((1 << n_rel) - 1));
        check("seq_done", SEQ_DONE, m_done);
        check("seq_err", SEQ_ERR, m_err);
        check("err_dom", ERR_DOM, m_err_dom);
    end

    // Returns at the falling edge just after rising edge n (edge 0 = first with RST high).
    task automatic after_edge(input int n);
        int guard = 0;
        while (e < n + 1 && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (e < n + 1) begin
            checks++;
            $display("FAIL after_edge(%0d) timeout: reached edge %0d", n, e - 1);
        end
    endtask

    task automatic pin(input string tag, input logic [N-1:0] rst_n, input logic done);
        check({tag, " dom_rst_n"}, DOM_RST_N, rst_n);
        check({tag, " seq_done"}, SEQ_DONE, done);
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        SW_RST_REQ = 1'b0;
        DOM_ACK = '0;
        @(negedge CLK);
        check("reset dom_rst_n", DOM_RST_N, 0);
        check("reset seq_done", SEQ_DONE, 0);
        check("reset seq_err", SEQ_ERR, 0);
        check("reset err_dom", ERR_DOM, 0);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic async_rst_pulse(input string tag);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check({tag, " async dom_rst_n"}, DOM_RST_N, 0);
        check({tag, " async seq_done"}, SEQ_DONE, 0);
        check({tag, " async seq_err"}, SEQ_ERR, 0);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        int mode;
        apply_reset();
`ifdef RST_SEQ_ACK_EN
        // Each ack raised two cycles after its domain's release.
        for (int k = 0; k <= 40; k++) begin
            after_edge(k);
            if (k == 14) DOM_ACK[0] = 1'b1;
            if (k == 25) DOM_ACK[1] = 1'b1;
            if (k == 36) DOM_ACK[2] = 1'b1;
            case (k)
                11: pin("A@11", 3'b000, 1'b0);
                12: pin("A@12", 3'b001, 1'b0);
                22: pin("A@22", 3'b001, 1'b0);
                23: pin("A@23", 3'b011, 1'b0);
                33: pin("A@33", 3'b011, 1'b0);
                34: pin("A@34", 3'b111, 1'b0);
                36: pin("A@36", 3'b111, 1'b0);
                37: pin("A@37", 3'b111, 1'b1);
                default: ;
            endcase
        end
`else
        for (int k = 0; k <= 40; k++) begin
            after_edge(k);
            case (k)
                11: pin("N@11", 3'b000, 1'b0);
                12: pin("N@12", 3'b001, 1'b0);
                19: pin("N@19", 3'b001, 1'b0);
                20: pin("N@20", 3'b011, 1'b0);
                27: pin("N@27", 3'b011, 1'b0);
                28: pin("N@28", 3'b111, 1'b1);
                default: ;
            endcase
        end
`endif
        // Software re-reset from DONE.
        after_edge(99);
        SW_RST_REQ = 1'b1;
        after_edge(100);
        SW_RST_REQ = 1'b0;
        pin("SW@100", 3'b000, 1'b0);
        after_edge(111);
        pin("SW@111", 3'b000, 1'b0);
        after_edge(112);
        pin("SW@112", 3'b001, 1'b0);

`ifdef RST_SEQ_ACK_EN
        // Domain 1 never acknowledges.
        apply_reset();
        after_edge(14);
        DOM_ACK = 3'b001;
        after_edge(277);
        pin("TO@277", 3'b011, 1'b0);
        check("TO@277 seq_err", SEQ_ERR, 0);
        after_edge(278);
        pin("TO@278", 3'b000, 1'b0);
        check("TO@278 seq_err", SEQ_ERR, 1);
        check("TO@278 err_dom", ERR_DOM, 3'b010);
        after_edge(290);
        SW_RST_REQ = 1'b1;
        check("TO@290 err_dom", ERR_DOM, 3'b010);
        after_edge(291);
        SW_RST_REQ = 1'b0;
        check("TO@291 seq_err", SEQ_ERR, 0);
        check("TO@291 err_dom", ERR_DOM, 0);
        after_edge(303);
        pin("TO@303", 3'b001, 1'b0);

        // Request and ack sampled on the same edge: request wins.
        apply_reset();
        after_edge(14);
        DOM_ACK = 3'b001;
        SW_RST_REQ = 1'b1;
        after_edge(15);
        SW_RST_REQ = 1'b0;
        pin("PRI@15", 3'b000, 1'b0);
        after_edge(26);
        pin("PRI@26", 3'b000, 1'b0);
        after_edge(27);
        pin("PRI@27", 3'b001, 1'b0);

        // Acks held high from reset.
        apply_reset();
        DOM_ACK = 3'b111;
        for (int k = 0; k <= 32; k++) begin
            after_edge(k);
            case (k)
                12: pin("ACK1@12", 3'b001, 1'b0);
                20: pin("ACK1@20", 3'b001, 1'b0);
                21: pin("ACK1@21", 3'b011, 1'b0);
                29: pin("ACK1@29", 3'b011, 1'b0);
                30: pin("ACK1@30", 3'b111, 1'b0);
                31: pin("ACK1@31", 3'b111, 1'b1);
                default: ;
            endcase
        end
`endif
        // Asynchronous reset mid-sequence at edge 25.
        apply_reset();
        DOM_ACK = 3'b111;
        after_edge(24);
        pin("RST@24", 3'b011, 1'b0);
        async_rst_pulse("RST@25");
        after_edge(12);
        pin("RST re@12", 3'b001, 1'b0);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 6; ep++) begin
            apply_reset();
            mode = ep % 4;
            for (int c = 0; c < 600; c++) begin
                @(negedge CLK);
                case (mode)
                    0: DOM_ACK = '0;
                    1: DOM_ACK = N'($urandom) & N'($urandom) & N'($urandom);
                    2: DOM_ACK = N'($urandom);
                    default: DOM_ACK = '1;
                endcase
                if (mode == 0) SW_RST_REQ = ($urandom_range(0, 499) == 0);
                else SW_RST_REQ = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 299) == 0) begin
                    SW_RST_REQ = 1'b0;
                    async_rst_pulse("rand");
                end
            end
        end

        SW_RST_REQ = 1'b0;
        @(negedge CLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
